dispatch_ctrl: RTL

//  Sequences decoded instructions from the decoder into the back end: buffers one

---
 rtl/dispatch_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: holds one decoded instruction, allocates a ROB tag and
// steers it to the RS or LSB, back-pressuring the decoder when a target is full.
module dispatch_ctrl #(
    parameter int ROB_IDX_W = 4,
    parameter int ROB_SLOTS = 15
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_in,
    input  logic                 dc_valid,
    input  logic [1:0]           dc_class,
    output logic                 dc_accept,
    input  logic                 rob_commit,
    input  logic                 rs_full,
    input  logic                 lsb_full,
    output logic                 rob_alloc,
    output logic                 rs_issue,
    output logic                 lsb_issue,
    output logic [ROB_IDX_W-1:0] issue_tag,
    output logic [15:0]          stall_cnt,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    localparam logic [1:0]           CLS_RS   = 2'd0;
    localparam logic [1:0]           CLS_DROP = 2'd3;
    localparam logic [ROB_IDX_W-1:0] SLOTS    = ROB_IDX_W'(ROB_SLOTS);
    localparam logic [ROB_IDX_W-1:0] TAG_ONE  = ROB_IDX_W'(1);

    state_t               state;
    logic [1:0]           held_class;
    logic [ROB_IDX_W-1:0] tail;
    logic [ROB_IDX_W-1:0] count;

    logic active;
    logic target_full;
    logic go;
    logic take;
    logic commit_ok;

    // Handshake: the decoder's instruction moves into the holding slot at any
    // clock edge where dc_accept && dc_valid; dc_accept never depends on dc_valid.
    // Reset and flush suppress every strobe in the cycle they are asserted.
    assign active      = rdy_in && !clear_in && !rst_in;
    assign target_full = (held_class == CLS_RS) ? rs_full : lsb_full;
    assign go          = active && (state == S_HOLD) && (count < SLOTS) && !target_full;
    assign dc_accept   = active && (state != S_FLUSH) && ((state == S_EMPTY) || go);
    assign take        = dc_accept && dc_valid && (dc_class != CLS_DROP);
    assign commit_ok   = rob_commit && (count != '0);

    assign rob_alloc = go;
    assign rs_issue  = go && (held_class == CLS_RS);
    assign lsb_issue = go && (held_class != CLS_RS);
    assign issue_tag = tail;
    assign state_dbg = state;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= S_EMPTY;
            held_class <= CLS_RS;
            tail       <= TAG_ONE;
            count      <= '0;
            stall_cnt  <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                state <= S_FLUSH;
                tail  <= TAG_ONE;
                count <= '0;
            end else begin
                if (go) begin
                    tail <= (tail == SLOTS) ? TAG_ONE : tail + TAG_ONE;
                end
                // A commit and an allocation in the same cycle cancel out.
                case ({go, commit_ok})
                    2'b10:   count <= count + TAG_ONE;
                    2'b01:   count <= count - TAG_ONE;
                    default: count <= count;
                endcase
                if ((state == S_HOLD) && !go && (stall_cnt != 16'hFFFF)) begin
                    stall_cnt <= stall_cnt + 16'd1;
                end
                case (state)
                    S_EMPTY: begin
                        if (take) begin
                            state      <= S_HOLD;
                            held_class <= dc_class;
                        end
                    end
                    S_HOLD: begin
                        if (take) begin
                            held_class <= dc_class;
                        end else if (go) begin
                            state <= S_EMPTY;
                        end
                    end
                    default: state <= S_EMPTY;
                endcase
            end
        end
    end

endmodule
